// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use stalls, redirect flushes, memory-wait freeze with timeout, and event counters.
module hazard_controller #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             MemAccessM,
    input  logic             DmemReadyM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] CntLoadUse,
    output logic [CNT_W-1:0] CntFlush,
    output logic [CNT_W-1:0] CntMemWait
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_stall;
    logic              lw_stall;
    logic              lw_eff;
    logic              flush_eff;
    logic              unused_result_src;

    // Only bit0 of the result select identifies a load.
    assign unused_result_src = ResultSrcE[1];

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign lw_stall = ResultSrcE[0] && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state and memory-stall decode
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        unique case (state)
            RUN: begin
                mem_stall = MemAccessM && !DmemReadyM;
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                mem_stall = !DmemReadyM;
                if (DmemReadyM)
                    state_nxt = RUN;
                else if (wait_cnt == WAIT_W'(WAIT_MAX))
                    state_nxt = ERROR;
                else
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
            ERROR: mem_stall = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    // Stall/flush priority: memory freeze, then redirect, then load-use
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        lw_eff    = 1'b0;
        flush_eff = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            flush_eff = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            lw_eff = 1'b1;
        end
    end

    assign MemTimeout = (state == ERROR);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            CntLoadUse <= '0;
            CntFlush   <= '0;
            CntMemWait <= '0;
        end else begin
            if (lw_eff && (CntLoadUse != '1))
                CntLoadUse <= CntLoadUse + CNT_W'(1);
            if (flush_eff && (CntFlush != '1))
                CntFlush <= CntFlush + CNT_W'(1);
            if (mem_stall && (CntMemWait != '1))
                CntMemWait <= CntMemWait + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller built with WAIT_MAX=4 and CNT_W=4.
module tb_hazard_controller;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, RegWriteM, MemAccessM, DmemReadyM, RegWriteW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [CNT_W-1:0] CntLoadUse, CntFlush, CntMemWait;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM), .DmemReadyM(DmemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout),
        .CntLoadUse(CntLoadUse), .CntFlush(CntFlush), .CntMemWait(CntMemWait)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and are sampled 1-3 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic stalls(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE}, {26'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, MemAccessM, DmemReadyM, RegWriteW} = '0;
        tick(); tick();
        settle();
        check("rst_cnt_lu", 32'(CntLoadUse), 0);
        check("rst_cnt_fl", 32'(CntFlush), 0);
        check("rst_cnt_mw", 32'(CntMemWait), 0);
        check("rst_timeout", 32'(MemTimeout), 0);
        stalls("rst_stalls", 6'b000000);
        tick();
        rst = 1'b0;

        // Forwarding: M over W, x0 never forwarded
        RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; settle();
        check("fwdA_mem", 32'(ForwardAE), 2);
        check("fwdB_none", 32'(ForwardBE), 0);
        RdM = 0; settle();
        check("fwdA_wb", 32'(ForwardAE), 1);
        RegWriteW = 0; settle();
        check("fwdA_rf", 32'(ForwardAE), 0);
        Rs1E = 0; Rs2E = 5; RdM = 5; RegWriteW = 1; settle();
        check("fwdB_mem", 32'(ForwardBE), 2);
        RdM = 0; settle();
        check("fwdB_wb", 32'(ForwardBE), 1);
        RegWriteW = 0; settle();
        check("fwdB_rf", 32'(ForwardBE), 0);
        RegWriteM = 0; Rs2E = 0;

        // Load-use
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; settle();
        stalls("lw_stall", 6'b110001);
        tick();
        check("lw_cnt1", 32'(CntLoadUse), 1);
        RdE = 0; settle();
        stalls("lw_rd0", 6'b000000);
        tick();
        check("lw_cnt_hold", 32'(CntLoadUse), 1);
        ResultSrcE = 2'b00; Rs2D = 0;

        // Branch, then branch masked by memory stall
        PCSrcE = 1; settle();
        stalls("br_flush", 6'b000011);
        tick();
        check("br_cnt1", 32'(CntFlush), 1);
        MemAccessM = 1; DmemReadyM = 0; settle();
        stalls("br_memstall", 6'b111100);
        tick();
        check("br_cnt_masked", 32'(CntFlush), 1);
        check("br_cnt_mw", 32'(CntMemWait), 1);
        PCSrcE = 0; MemAccessM = 0; DmemReadyM = 1; settle();
        stalls("br_mw_release", 6'b000000);
        tick();

        // Memory wait: three stalled cycles then ready
        MemAccessM = 1; DmemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            stalls($sformatf("mw_stall%0d", i), 6'b111100);
            tick();
        end
        DmemReadyM = 1; settle();
        stalls("mw_ready", 6'b000000);
        tick();
        check("mw_cnt", 32'(CntMemWait), 4);
        check("mw_timeout", 32'(MemTimeout), 0);
        MemAccessM = 0; settle();
        stalls("mw_run", 6'b000000);

        // Timeout: RUN cycle plus WAIT_MAX wait cycles, then ERROR
        MemAccessM = 1; DmemReadyM = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("to_flag%0d", i), 32'(MemTimeout), (i == 5) ? 1 : 0);
        end
        check("to_cnt_mw", 32'(CntMemWait), 9);
        MemAccessM = 0; DmemReadyM = 1; settle();
        stalls("err_stall", 6'b111100);
        check("err_flag", 32'(MemTimeout), 1);
        for (int i = 0; i < 8; i++) tick();
        check("mw_saturate", 32'(CntMemWait), 15);
        check("err_sticky", 32'(MemTimeout), 1);
        rst = 1'b1;
        tick();
        settle();
        check("rst2_timeout", 32'(MemTimeout), 0);
        check("rst2_cnt_mw", 32'(CntMemWait), 0);
        check("rst2_cnt_lu", 32'(CntLoadUse), 0);
        check("rst2_cnt_fl", 32'(CntFlush), 0);
        stalls("rst2_stalls", 6'b000000);
        rst = 1'b0;
        tick();

        // Branch wins over load-use when both asserted
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; settle();
        stalls("prio_br", 6'b000011);
        tick();
        check("prio_cnt_fl", 32'(CntFlush), 1);
        check("prio_cnt_lu", 32'(CntLoadUse), 0);
        PCSrcE = 0;

        // Load-use counter saturates
        for (int i = 0; i < 20; i++) tick();
        check("lu_saturate", 32'(CntLoadUse), 15);
        settle();
        stalls("lu_still", 6'b110001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Generates EX-stage operand forwarding selects, load-use stalls, and branch/jump flushes.
- Freezes the whole pipeline while the data memory is not ready; a memory-wait FSM with timeout handles this.
- Keeps saturating performance counters for stall and flush events.
- Sits beside the fetch, decode, execute and memory stage registers and drives their enable and clear inputs.

Parameters:
- WAIT_MAX, 16: max consecutive memory-wait cycles before a timeout error is raised (1..255).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- Rs1D, Rs2D  in  5  source register fields in decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in execute.
- ResultSrcE  in  2  result-select in execute; bit0=1 marks a load.
- PCSrcE  in  1  taken branch or jump in execute.
- RdM  in  5  destination register in memory stage.
- RegWriteM  in  1  write enable in memory stage.
- MemAccessM  in  1  load or store present in memory stage.
- DmemReadyM  in  1  data memory completes the access this cycle.
- RdW  in  5  destination register in writeback.
- RegWriteW  in  1  write enable in writeback.
- ForwardAE, ForwardBE  out  2  operand select: 00=register file, 01=ResultW, 10=ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding stage register.
- FlushD, FlushE  out  1  synchronously clear the decode/execute stage register to a bubble.
- MemTimeout  out  1  sticky error flag.
- CntLoadUse, CntFlush, CntMemWait  out  CNT_W  performance counters.

Behaviour:
- Forwarding (combinational, always active):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - The memory stage has priority over writeback.
- lwStall = ResultSrcE[0] && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). Conservative: unused source fields may still match.
- FSM states: RUN, MEM_WAIT, ERROR. rst forces RUN from any state, including mid-wait.
- RUN:
  - memStall = MemAccessM && !DmemReadyM.
  - If memStall: go to MEM_WAIT and load waitCnt=1.
- MEM_WAIT:
  - memStall = !DmemReadyM.
  - If DmemReadyM: go to RUN. Outputs in that cycle are already non-stalled.
  - Else if waitCnt==WAIT_MAX: go to ERROR.
  - Else waitCnt increments.
- ERROR:
  - memStall=1 permanently and MemTimeout=1.
  - Exit only via rst.
- Output priority, highest first:
  - memStall: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0. Load-use and redirect are deferred because E and M hold and their inputs stay stable.
  - PCSrcE: FlushD=1, FlushE=1, StallF=StallD=0.
  - lwStall: StallF=StallD=1, FlushE=1, FlushD=0.
  - Otherwise all stall and flush outputs are 0.
- PCSrcE and lwStall are mutually exclusive in legal code (jal uses ResultSrc=10). The priority above still holds if both are asserted.
- Performance counters, updated on the clk edge:
  - CntLoadUse increments each cycle lwStall is effective, i.e. not masked by memStall or PCSrcE.
  - CntFlush increments each cycle PCSrcE is effective.
  - CntMemWait increments each cycle memStall=1, including ERROR.
  - All counters saturate at 2^CNT_W-1; there is no wrap.
- Reset values: state=RUN, waitCnt=0, MemTimeout=0, all counters=0.
- With rst asserted, combinational outputs follow the inputs in RUN state: no memStall history and no error.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Set RegWriteW=0 -> 00. Rs2E=5 gives the same results on ForwardBE.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1, FlushD=0, CntLoadUse 0->1. With RdE=0 -> no stall.
- Branch: PCSrcE=1 for 1 cycle -> FlushD=FlushE=1, StallF=0, CntFlush=1. Same cycle with memStall active -> all Stall*=1, flushes 0, CntFlush unchanged.
- Memory wait: MemAccessM=1, DmemReadyM=0 for 3 cycles then 1 -> all Stall*=1 for exactly 3 cycles, state back to RUN, CntMemWait=3, MemTimeout=0.
- Timeout: WAIT_MAX=4, DmemReadyM held 0 -> ERROR entered after the 4th wait cycle. MemTimeout=1 and stalls stay asserted after DmemReadyM rises. rst clears state to RUN and all counters and flags to 0.
- Saturation: CNT_W=4, 20 consecutive load-use cycles -> CntLoadUse stops at 15.
